// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding scoreboard: pipeline tag layout,
// the register-file select code and the select-width / producer helpers.
package fwd_pkg;

  // Widest register address a tag can carry; narrower addresses are zero-extended.
  localparam int FWD_RD_MAXW = 8;
  localparam int FWD_SEL_RF  = 0;

  typedef struct packed {
    logic                   valid;
    logic [FWD_RD_MAXW-1:0] rd;
    logic                   regwrite;
    logic                   memtoreg;
  } fwd_tag_t;

  function automatic int fwd_selw(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic fwd_is_producer(input fwd_tag_t t);
    return t.valid && t.regwrite && (t.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Priority encoder for one source operand: returns the youngest post-EX stage
// whose tag produces the source register, or the register-file code.
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int REG_AW = 5,
  parameter int SELW   = fwd_selw(DEPTH)
) (
  input  logic                    en_i,
  input  logic [REG_AW-1:0]       src_i,
  input  fwd_tag_t [DEPTH-1:0]    tags_i,
  output logic [SELW-1:0]         sel_o
);

  logic [FWD_RD_MAXW-1:0] src_ext;
  logic [DEPTH-1:0]       unused_memtoreg;

  assign src_ext = FWD_RD_MAXW'(src_i);

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    sel_o = SELW'(FWD_SEL_RF);
    if (en_i) begin
      // Scan oldest to youngest so the youngest match is the last write and wins.
      for (int k = DEPTH; k >= 1; k--) begin
        if (fwd_is_producer(tags_i[k-1]) && (tags_i[k-1].rd == src_ext)) begin
          sel_o = SELW'(k);
        end
      end
    end
  end

  always_comb begin
    unused_memtoreg = '0;
    for (int k = 0; k < DEPTH; k++) begin
      unused_memtoreg[k] = tags_i[k].memtoreg;
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use hazard unit built on a tag pipeline of in-flight
// destinations. Define FWD_STATS_EN to add the stall/forward event counters.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 2,
  parameter int REG_AW     = 5,
  parameter int LOAD_READY = 2,
  localparam int SELW      = fwd_selw(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_regwrite,
  input  logic                      id_memtoreg,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic                      flush,
  input  logic                      hold,
  output logic                      stall_out,
  output logic [NUM_SRC*SELW-1:0]   fwd_sel
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]               stall_cnt,
  output logic [31:0]               fwd_cnt
`endif
);

  // tag_q[0] mirrors ID/EX, tag_q[k] mirrors post-EX stage k.
  fwd_tag_t [DEPTH:0]          tag_q, tag_d;
  logic [NUM_SRC*REG_AW-1:0]   rs_q, rs_d;
  logic                        load_use;

  always_comb begin
    load_use = 1'b0;
    for (int k = 0; k <= LOAD_READY - 2; k++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (fwd_is_producer(tag_q[k]) && tag_q[k].memtoreg &&
            (tag_q[k].rd == FWD_RD_MAXW'(id_rs[i*REG_AW +: REG_AW]))) begin
          load_use = 1'b1;
        end
      end
    end
  end

  assign stall_out = id_valid && load_use;

  always_comb begin
    tag_d = tag_q;
    rs_d  = rs_q;
    if (!hold) begin
      for (int k = 1; k <= DEPTH; k++) begin
        tag_d[k] = tag_q[k-1];
      end
      if (stall_out || flush) begin
        tag_d[0] = '0;
      end else begin
        tag_d[0].valid    = id_valid;
        tag_d[0].rd       = FWD_RD_MAXW'(id_rd);
        tag_d[0].regwrite = id_regwrite;
        tag_d[0].memtoreg = id_memtoreg;
        rs_d              = id_rs;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every stage samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the tag pipeline is a handful of flops, not a RAM, so it is cleared on reset in full.
      tag_q <= '0;
      rs_q  <= '0;
    end else begin
      tag_q <= tag_d;
      rs_q  <= rs_d;
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_match #(
      .DEPTH  (DEPTH),
      .REG_AW (REG_AW),
      .SELW   (SELW)
    ) u_match (
      .en_i   (tag_q[0].valid),
      .src_i  (rs_q[i*REG_AW +: REG_AW]),
      .tags_i (tag_q[DEPTH:1]),
      .sel_o  (fwd_sel[i*SELW +: SELW])
    );
  end

`ifdef FWD_STATS_EN
  logic [31:0] stall_cnt_q, fwd_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else if (!hold) begin
      if (stall_out) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (|fwd_sel)  fwd_cnt_q   <= fwd_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard (default parameters): reset, forwarding,
// priority, load-use, flush and hold scenarios with hand-computed selects.
module tb_fwd_scoreboard;

  localparam int NUM_SRC    = 2;
  localparam int DEPTH      = 2;
  localparam int REG_AW     = 5;
  localparam int LOAD_READY = 2;
  localparam int SELW       = 2;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      id_valid;
  logic [REG_AW-1:0]         id_rd;
  logic                      id_regwrite;
  logic                      id_memtoreg;
  logic [NUM_SRC*REG_AW-1:0] id_rs;
  logic                      flush;
  logic                      hold;
  logic                      stall_out;
  logic [NUM_SRC*SELW-1:0]   fwd_sel;
`ifdef FWD_STATS_EN
  logic [31:0]               stall_cnt;
  logic [31:0]               fwd_cnt;
  logic [31:0]               c0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fwd_scoreboard #(
    .NUM_SRC    (NUM_SRC),
    .DEPTH      (DEPTH),
    .REG_AW     (REG_AW),
    .LOAD_READY (LOAD_READY)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memtoreg (id_memtoreg),
    .id_rs       (id_rs),
    .flush       (flush),
    .hold        (hold),
    .stall_out   (stall_out),
    .fwd_sel     (fwd_sel)
`ifdef FWD_STATS_EN
    ,
    .stall_cnt   (stall_cnt),
    .fwd_cnt     (fwd_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                       input logic [4:0] rs0, input logic [4:0] rs1);
    id_valid    = v;
    id_rd       = rd;
    id_regwrite = rw;
    id_memtoreg = mr;
    id_rs       = {rs1, rs0};
  endtask

  task automatic drain();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    repeat (DEPTH + 1) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    hold  = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL reset_fwd_sel: got %b expected %b", fwd_sel, 4'b0000); end
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected %b", stall_out, 1'b0); end
`ifdef FWD_STATS_EN
    checks++; if (stall_cnt !== 32'd0 || fwd_cnt !== 32'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cnt, fwd_cnt); end
`endif
    rst_n = 1'b1;
    // Build live state: add x5 in stage 1, lw x7 (reads x5) in EX, dependent add in ID.
    drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 5'd2);
    step();
    drive(1'b1, 5'd7, 1'b1, 1'b1, 5'd5, 5'd0);
    step();
    drive(1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 5'd1);
    settle();
    checks++; if (fwd_sel !== 4'b0001) begin errors++; $display("FAIL pre_reset_fwd_sel: got %b expected %b", fwd_sel, 4'b0001); end
    checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL pre_reset_stall: got %b expected %b", stall_out, 1'b1); end
    rst_n = 1'b0;
    #1;
    checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL async_reset_fwd_sel: got %b expected %b", fwd_sel, 4'b0000); end
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL async_reset_stall: got %b expected %b", stall_out, 1'b0); end
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    step();
    drive(1'b1, 5'd1, 1'b1, 1'b0, 5'd5, 5'd5);
    step();
    settle();
    checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL post_reset_no_fwd: got %b expected %b", fwd_sel, 4'b0000); end
  endtask

  task automatic test_back_to_back();
    drain();
    drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 5'd2);
    step();
    drive(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 5'd5);
    step();
    settle();
    checks++; if (fwd_sel !== 4'b0101) begin errors++; $display("FAIL b2b_fwd_sel: got %b expected %b", fwd_sel, 4'b0101); end
    drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    settle();
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL b2b_alu_no_stall: got %b expected %b", stall_out, 1'b0); end
    step();
    settle();
    checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL b2b_invalid_ex: got %b expected %b", fwd_sel, 4'b0000); end
  endtask

  task automatic test_two_producers();
    drain();
    drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 5'd2);
    step();
    drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd3, 5'd4);
    step();
    drive(1'b1, 5'd11, 1'b1, 1'b0, 5'd5, 5'd3);
    step();
    settle();
    checks++; if (fwd_sel !== 4'b0001) begin errors++; $display("FAIL youngest_wins: got %b expected %b", fwd_sel, 4'b0001); end
    drive(1'b1, 5'd10, 1'b1, 1'b0, 5'd5, 5'd3);
    step();
    settle();
    checks++; if (fwd_sel !== 4'b0010) begin errors++; $display("FAIL stage2_fwd: got %b expected %b", fwd_sel, 4'b0010); end
    drain();
    drive(1'b1, 5'd0, 1'b1, 1'b0, 5'd1, 5'd2);
    step();
    drive(1'b1, 5'd12, 1'b1, 1'b0, 5'd0, 5'd0);
    step();
    settle();
    checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL x0_no_fwd: got %b expected %b", fwd_sel, 4'b0000); end
    drive(1'b1, 5'd4, 1'b0, 1'b0, 5'd1, 5'd2);
    step();
    drive(1'b1, 5'd13, 1'b1, 1'b0, 5'd4, 5'd4);
    step();
    settle();
    checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL no_regwrite_no_fwd: got %b expected %b", fwd_sel, 4'b0000); end
  endtask

  task automatic test_load_use();
    drain();
    drive(1'b1, 5'd7, 1'b1, 1'b1, 5'd2, 5'd0);
    step();
    drive(1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 5'd1);
    settle();
    checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL load_use_stall: got %b expected %b", stall_out, 1'b1); end
    step();
    settle();
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL load_use_one_cycle: got %b expected %b", stall_out, 1'b0); end
    checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL load_use_bubble: got %b expected %b", fwd_sel, 4'b0000); end
    step();
    settle();
    checks++; if (fwd_sel !== 4'b0010) begin errors++; $display("FAIL load_use_fwd: got %b expected %b", fwd_sel, 4'b0010); end
    drain();
    drive(1'b1, 5'd7, 1'b1, 1'b1, 5'd2, 5'd0);
    step();
    drive(1'b1, 5'd8, 1'b1, 1'b0, 5'd1, 5'd7);
    settle();
    checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL load_use_rs1: got %b expected %b", stall_out, 1'b1); end
    id_valid = 1'b0;
    settle();
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL load_use_id_invalid: got %b expected %b", stall_out, 1'b0); end
  endtask

  task automatic test_flush();
    drain();
    drive(1'b1, 5'd9, 1'b1, 1'b0, 5'd1, 5'd2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b1, 5'd12, 1'b1, 1'b0, 5'd9, 5'd9);
    step();
    settle();
    checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL flush_killed: got %b expected %b", fwd_sel, 4'b0000); end
  endtask

  task automatic test_hold();
    drain();
    drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 5'd2);
    step();
    drive(1'b1, 5'd7, 1'b1, 1'b1, 5'd5, 5'd0);
    step();
    drive(1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 5'd1);
    hold = 1'b1;
    settle();
`ifdef FWD_STATS_EN
    c0 = stall_cnt;
`endif
    for (int c = 0; c < 3; c++) begin
      step();
      settle();
      checks++; if (fwd_sel !== 4'b0001) begin errors++; $display("FAIL hold_frozen_fwd[%0d]: got %b expected %b", c, fwd_sel, 4'b0001); end
      checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL hold_frozen_stall[%0d]: got %b expected %b", c, stall_out, 1'b1); end
    end
    hold = 1'b0;
    step();
    settle();
    checks++; if (stall_out !== 1'b0 || fwd_sel !== 4'b0000) begin errors++; $display("FAIL hold_release: got stall=%b fwd=%b expected stall=0 fwd=0000", stall_out, fwd_sel); end
    step();
    settle();
    checks++; if (fwd_sel !== 4'b0010) begin errors++; $display("FAIL hold_load_fwd: got %b expected %b", fwd_sel, 4'b0010); end
`ifdef FWD_STATS_EN
    checks++; if (stall_cnt !== c0 + 32'd1) begin errors++; $display("FAIL hold_stall_cnt: got %0d expected %0d", stall_cnt, c0 + 32'd1); end
`endif
    drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_two_producers();
    test_load_use();
    test_flush();
    test_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
